ins_loader: RTL and testbench
=============================

Name: ins_loader

Overview:
- Boot-time writer for the processor's word-addressed instruction memory, which the core otherwise only reads.
- Receives a framed byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word sequentially into instruction memory from word address 0.
- Holds the core (cpu_hold) until the image is loaded and its checksum verified.

Parameters:
- ADDR_W, 8, instruction memory word-address width.
- DEPTH, 256, number of instruction words; must be <= 2^ADDR_W.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-low reset, sampled on rising clk
- start  input  1  pulse; restarts a load from DONE or ERR, ignored in other states
- in_valid  input  1  byte present on in_data
- in_data  input  8  stream byte
- in_ready  output  1  loader accepts a byte this cycle
- wr_en  output  1  instruction memory write strobe, one cycle per word
- wr_addr  output  ADDR_W  word address for the write
- wr_data  output  32  word for the write
- cpu_hold  output  1  high keeps the core's PC and register bank in reset
- done  output  1  image loaded and checksum good
- err  output  1  load failed: bad count or bad checksum

Behaviour:
- Frame format, in order:
  - CNT_HI, CNT_LO: 16-bit word count N, big-endian.
  - N words, 4 bytes each, MSB first.
  - CHK: XOR of every preceding byte in the frame.
- A byte is accepted on a rising edge where in_valid && in_ready.
- States and in_ready:
  - HDR_HI, HDR_LO, WORD, CHK: in_ready = 1.
  - WRITE, DONE, ERR: in_ready = 0.
- Reset (rst == 0 at an edge), including mid-load, gives:
  - state = HDR_HI;
  - byte_cnt = 0, word_idx = 0, xor_acc = 0;
  - wr_en = 0, wr_addr = 0, wr_data = 0;
  - cpu_hold = 1, done = 0, err = 0.
  - A partially written memory is not cleared.
- HDR_HI: on accept, store in_data as count[15:8]; xor_acc ^= in_data; go to HDR_LO.
- HDR_LO: on accept, store in_data as count[7:0] and fold it into xor_acc, then:
  - count > DEPTH: go to ERR;
  - count == 0: go to CHK;
  - otherwise: go to WORD.
- WORD: on accept:
  - shift in_data into a 32-bit assembly register from the MSB side: first byte lands in [31:24], fourth in [7:0];
  - xor_acc ^= in_data; byte_cnt increments modulo 4;
  - on the 4th byte go to WRITE.
- WRITE, exactly one cycle:
  - wr_en = 1, wr_addr = word_idx, wr_data = assembled word, all registered;
  - word_idx increments;
  - if word_idx + 1 == count, go to CHK, else back to WORD.
- wr_en is high only during WRITE; wr_addr and wr_data hold their last value otherwise.
- CHK: on accept:
  - in_data == xor_acc: go to DONE;
  - otherwise: go to ERR.
- DONE: done = 1, cpu_hold = 0, both registered, so the first cycle in DONE shows them.
- ERR: err = 1, cpu_hold stays 1.
- start in DONE or ERR gives:
  - next state HDR_HI;
  - done = 0, err = 0, cpu_hold = 1;
  - counters and xor_acc cleared.
- start in any other state has no effect.
- If rst is low and start is high at the same edge, reset wins.
- Bytes offered while in_ready = 0 are not consumed; the source must hold in_valid/in_data (standard valid/ready).
- No timeout; the loader waits indefinitely for bytes.
- Latency: the write for a word occurs the cycle after its 4th byte is accepted. done rises the cycle after the CHK byte is accepted.
- word_idx is ADDR_W+1 bits wide so that count == DEPTH is representable.

Test Plan:
- Single word: stream 00 01 20 00 00 05, then CHK 24, in_valid constant -> one wr_en pulse with wr_addr=0, wr_data=0x20000005; done=1, cpu_hold=0 one cycle after CHK is accepted.
- Bad checksum: same frame with CHK 25 -> one write occurs, then err=1, cpu_hold=1, done=0, in_ready=0.
- Oversize count: with DEPTH=256, stream 01 01 -> ERR right after CNT_LO, no wr_en ever.
- Zero count: stream 00 00 00 -> DONE, no writes.
- Gapped valid with three words 0x11111111, 0x22222222, 0xAABBCCDD, random in_valid gaps -> writes to addresses 0, 1, 2 with exact data; in_ready low on each WRITE cycle.
- Reset mid-WORD after 2 bytes (rst=0 one edge), then a full 1-word frame -> clean reload; first write at addr 0 contains only new bytes; start pulse in DONE re-raises cpu_hold.

Source files
------------

// File: rtl/ins_loader.sv
// Boot-time instruction memory loader: assembles a framed, XOR-checked byte stream
// into big-endian 32-bit words and writes them from word address 0, holding the core until done.
module ins_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [15:0] DEPTH_CNT = 16'(DEPTH);

  typedef enum logic [2:0] {
    S_HDR_HI,
    S_HDR_LO,
    S_WORD,
    S_WRITE,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [15:0]     count;
  logic [1:0]      byte_cnt;
  logic [ADDR_W:0] word_idx;
  logic [7:0]      xor_acc;
  logic [23:0]     asm_word;
  logic            accept;
  logic [15:0]     count_lo;
  logic [15:0]     idx_inc;

  assign accept   = in_valid && in_ready;
  assign count_lo = {count[15:8], in_data};
  assign idx_inc  = 16'(word_idx) + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_HDR_HI;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HDR_HI: if (accept) state_nxt = S_HDR_LO;
      S_HDR_LO: begin
        if (accept) begin
          if (count_lo > DEPTH_CNT)  state_nxt = S_ERR;
          else if (count_lo == 16'd0) state_nxt = S_CHK;
          else                        state_nxt = S_WORD;
        end
      end
      S_WORD:   if (accept && byte_cnt == 2'd3) state_nxt = S_WRITE;
      S_WRITE:  state_nxt = (idx_inc == count) ? S_CHK : S_WORD;
      S_CHK: begin
        if (accept) state_nxt = (in_data == xor_acc) ? S_DONE : S_ERR;
      end
      S_DONE:   if (start) state_nxt = S_HDR_HI;
      S_ERR:    if (start) state_nxt = S_HDR_HI;
      default:  state_nxt = S_HDR_HI;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_HDR_HI, S_HDR_LO, S_WORD, S_CHK: in_ready = 1'b1;
      default:                           in_ready = 1'b0;
    endcase
  end

  // Status strobes are registered from the next state so they appear on the first cycle of that state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_en    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_hold <= 1'b1;
    end else begin
      wr_en    <= (state_nxt == S_WRITE);
      done     <= (state_nxt == S_DONE);
      err      <= (state_nxt == S_ERR);
      cpu_hold <= (state_nxt != S_DONE);
    end
  end

  // Write address/data are captured with the 4th byte and held until the next word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count    <= '0;
      byte_cnt <= '0;
      word_idx <= '0;
      xor_acc  <= '0;
      asm_word <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else begin
      case (state)
        S_HDR_HI: begin
          if (accept) begin
            count[15:8] <= in_data;
            xor_acc     <= xor_acc ^ in_data;
          end
        end
        S_HDR_LO: begin
          if (accept) begin
            count[7:0] <= in_data;
            xor_acc    <= xor_acc ^ in_data;
          end
        end
        S_WORD: begin
          if (accept) begin
            asm_word <= {asm_word[15:0], in_data};
            xor_acc  <= xor_acc ^ in_data;
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wr_addr <= word_idx[ADDR_W-1:0];
              wr_data <= {asm_word, in_data};
            end
          end
        end
        S_WRITE: word_idx <= word_idx + 1'b1;
        S_DONE, S_ERR: begin
          if (start) begin
            byte_cnt <= '0;
            word_idx <= '0;
            xor_acc  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ins_loader.sv
// Directed self-checking bench for ins_loader: framing, checksum, bounds, gaps, reset and restart.
module tb_ins_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int nw = 0;
  int base;
  logic [7:0]  wa [16];
  logic [31:0] wd [16];
  logic        wr_rdy [16];
  logic [7:0]  frame [$];

  ins_loader #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every memory write seen mid-cycle, along with in_ready at that moment.
  always @(negedge clk) begin
    if (wr_en && nw < 16) begin
      wa[nw]     <= wr_addr;
      wd[nw]     <= wr_data;
      wr_rdy[nw] <= in_ready;
      nw         <= nw + 1;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("ready_tmo", 32'd0, 32'd1);
    @(posedge clk);
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame[i]) begin
      if (max_gap > 0) idle($urandom_range(0, max_gap));
      send_byte(frame[i]);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_ready", in_ready, 1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_hold", cpu_hold, 1);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);

    // Single word, checksum 0x24
    base = nw;
    frame = '{8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h05, 8'h24};
    send_frame(0);
    #1;
    chk("t1_done", done, 1);
    chk("t1_hold", cpu_hold, 0);
    chk("t1_err", err, 0);
    chk("t1_ready", in_ready, 0);
    chk("t1_nwr", nw - base, 1);
    chk("t1_addr", wa[base], 32'h0);
    chk("t1_data", wd[base], 32'h20000005);
    chk("t1_wr_rdy", wr_rdy[base], 0);
    pulse_start();
    chk("t1_start_hold", cpu_hold, 1);
    chk("t1_start_done", done, 0);
    chk("t1_start_ready", in_ready, 1);

    // Bad checksum
    base = nw;
    frame = '{8'h00, 8'h01, 8'h20, 8'h00, 8'h00, 8'h05, 8'h25};
    send_frame(0);
    #1;
    chk("t2_err", err, 1);
    chk("t2_hold", cpu_hold, 1);
    chk("t2_done", done, 0);
    chk("t2_ready", in_ready, 0);
    chk("t2_nwr", nw - base, 1);
    pulse_start();
    chk("t2_start_err", err, 0);

    // Oversize count 257
    base = nw;
    frame = '{8'h01, 8'h01};
    send_frame(0);
    #1;
    chk("t3_err", err, 1);
    idle(5);
    chk("t3_nwr", nw - base, 0);
    chk("t3_ready", in_ready, 0);
    pulse_start();

    // Zero count, with a start pulse in CHK that must be ignored
    base = nw;
    frame = '{8'h00, 8'h00};
    send_frame(0);
    pulse_start();
    frame = '{8'h00};
    send_frame(0);
    #1;
    chk("t4_done", done, 1);
    chk("t4_hold", cpu_hold, 0);
    chk("t4_nwr", nw - base, 0);
    pulse_start();

    // Three words with random valid gaps; checksum 0x03
    base = nw;
    frame = '{8'h00, 8'h03, 8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22,
              8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h03};
    send_frame(2);
    #1;
    chk("t5_done", done, 1);
    chk("t5_nwr", nw - base, 3);
    chk("t5_addr0", wa[base], 32'h0);
    chk("t5_data0", wd[base], 32'h11111111);
    chk("t5_addr1", wa[base+1], 32'h1);
    chk("t5_data1", wd[base+1], 32'h22222222);
    chk("t5_addr2", wa[base+2], 32'h2);
    chk("t5_data2", wd[base+2], 32'hAABBCCDD);
    chk("t5_rdy0", wr_rdy[base], 0);
    chk("t5_rdy1", wr_rdy[base+1], 0);
    chk("t5_rdy2", wr_rdy[base+2], 0);
    pulse_start();

    // Reset after two data bytes, then a clean one-word frame (checksum 0x09)
    frame = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_frame(0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("t6_rst_ready", in_ready, 1);
    chk("t6_rst_addr", wr_addr, 0);
    chk("t6_rst_data", wr_data, 0);
    chk("t6_rst_hold", cpu_hold, 1);
    chk("t6_rst_done", done, 0);
    base = nw;
    frame = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_frame(0);
    #1;
    chk("t6_done", done, 1);
    chk("t6_nwr", nw - base, 1);
    chk("t6_addr", wa[base], 32'h0);
    chk("t6_data", wd[base], 32'h12345678);
    pulse_start();
    chk("t6_start_hold", cpu_hold, 1);
    chk("t6_start_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
